// File: rtl/pci_bus_arbiter.sv
// -----------------------------------------------------------------------------
// pci_bus_arbiter
//
// Central round-robin arbiter for a PCI bus shared by three masters (A, B, C).
// Each master requests with an active-low Req_x and is granted with an
// active-low GNT_x. FRAME and IRDY are monitored to learn when a granted master
// has started its transaction and when the bus returns to idle.
//
// Guarantees:
//   - at most one GNT is low at any time;
//   - a grant never passes directly from one master to another: there is
//     always at least one clock with every GNT high in between;
//   - a master that is granted but never asserts FRAME loses the grant after
//     GNT_TIMEOUT clocks, and the search pointer moves past it.
//
// Parameters:
//   GNT_TIMEOUT  clocks a granted master may idle before its grant is revoked
//                (must be >= 1)
//   PARK_DEV     device parked on when nothing is requested (0=A, 1=B, 2=C);
//                only meaningful when ARB_BUS_PARK_EN is defined
//
// Optional feature (compile-time macro ARB_BUS_PARK_EN):
//   defined   -> with no request pending, PARK_DEV is granted (bus parking).
//   undefined -> all GNT are high whenever no request is pending.
//
// Ports:
//   Clk        in   bus clock, rising edge active
//   Rst_n      in   asynchronous active-low reset
//   Req_A/B/C  in   requests, active low
//   Frame      in   PCI FRAME#, active low
//   IRDY       in   PCI IRDY#, active low
//   GNT_A/B/C  out  grants, active low, registered
//   Bus_Owner  out  0=none, 1=A, 2=B, 3=C: master of current/last transaction
//   Bus_Busy   out  registered (!Frame || !IRDY)
// -----------------------------------------------------------------------------
module pci_bus_arbiter #(
   parameter int GNT_TIMEOUT = 16,
   parameter int PARK_DEV    = 0
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Req_A,
   input  logic       Req_B,
   input  logic       Req_C,
   input  logic       Frame,
   input  logic       IRDY,
   output logic       GNT_A,
   output logic       GNT_B,
   output logic       GNT_C,
   output logic [1:0] Bus_Owner,
   output logic       Bus_Busy
);

   localparam int         CNT_W    = $clog2(GNT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GNT_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GNT_TIMEOUT - 1);
   localparam logic [1:0] PARK_IDX = 2'(PARK_DEV);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BUSY  = 2'd2,
      ST_PARK  = 2'd3
   } state_t;

   // Device index d (0..2) advanced by k positions in the order A->B->C->A.
   function automatic logic [1:0] rot(input logic [1:0] base, input int k);
      int s;
      s = (int'(base) + k) % 3;
      return 2'(s);
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] idx);
      return 3'b001 << idx;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t           state_reg;
   logic [2:0]       gnt_reg;     // active-high one-hot grant, bit0 = A
   logic [1:0]       dev_reg;     // index of the device holding gnt_reg
   logic [1:0]       ptr_reg;     // first device to consider in the search
   logic [CNT_W-1:0] cnt_reg;
   logic [1:0]       owner_reg;
   logic             busy_reg;

   // ---------------------------------------------------------------------
   // Request decode and round-robin winner
   // ---------------------------------------------------------------------
   logic [2:0] req_vec;
   logic [1:0] cand_idx [3];      // search order starting at ptr_reg
   logic       win_valid;
   logic [1:0] win_idx;
   logic       granted_req;
   logic       other_req;
   logic       frame_start;
   logic       bus_idle;

   assign req_vec = ~{Req_C, Req_B, Req_A};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_cand
         assign cand_idx[gi] = rot(ptr_reg, gi);
      end
   endgenerate

   // Scan from lowest to highest priority so the last hit (closest to the
   // pointer) wins.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = ptr_reg;
      for (int k = 2; k >= 0; k--) begin
         if (req_vec[cand_idx[k]]) begin
            win_valid = 1'b1;
            win_idx   = cand_idx[k];
         end
      end
   end

   assign granted_req = |(req_vec & onehot(dev_reg));
   assign other_req   = |(req_vec & ~onehot(dev_reg));
   // A transaction start is FRAME going low on a bus that was idle in the
   // previous clock; FRAME still low from someone else's transfer is not
   // taken as the granted master starting.
   assign frame_start = !Frame && !busy_reg;
   assign bus_idle    = Frame && IRDY;

   // ---------------------------------------------------------------------
   // Arbiter FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg <= ST_IDLE;
         gnt_reg   <= 3'b000;
         dev_reg   <= PARK_IDX;
         ptr_reg   <= 2'd0;
         cnt_reg   <= '0;
         owner_reg <= 2'd0;
         busy_reg  <= 1'b0;
      end else begin
         busy_reg <= !Frame || !IRDY;

         case (state_reg)
            // All grants high here, so any grant issued from IDLE already
            // has its gap cycle behind it.
            ST_IDLE: begin
               cnt_reg <= '0;
               if (win_valid) begin
                  gnt_reg   <= onehot(win_idx);
                  dev_reg   <= win_idx;
                  state_reg <= ST_GRANT;
               end else begin
`ifdef ARB_BUS_PARK_EN
                  gnt_reg   <= onehot(PARK_IDX);
                  dev_reg   <= PARK_IDX;
                  state_reg <= ST_PARK;
`else
                  gnt_reg   <= 3'b000;
`endif
               end
            end

            // Precedence: transaction start, then request withdrawal,
            // then timeout.
            ST_GRANT: begin
               if (frame_start) begin
                  state_reg <= ST_BUSY;
                  owner_reg <= dev_reg + 2'd1;
                  ptr_reg   <= rot(dev_reg, 1);
                  cnt_reg   <= '0;
               end else if (!granted_req) begin
                  gnt_reg   <= 3'b000;
                  state_reg <= ST_IDLE;
                  cnt_reg   <= '0;
               end else if (cnt_reg >= CNT_LAST) begin
                  gnt_reg   <= 3'b000;
                  ptr_reg   <= rot(dev_reg, 1);
                  state_reg <= ST_IDLE;
                  cnt_reg   <= '0;
               end else if (cnt_reg < CNT_MAX) begin
                  cnt_reg   <= cnt_reg + 1'b1;
               end
            end

            // The owner keeps its grant (for back-to-back transfers) until
            // someone else asks; then it is removed and the new winner is
            // chosen once the bus has gone idle.
            ST_BUSY: begin
               cnt_reg <= '0;
               if (other_req) begin
                  gnt_reg <= 3'b000;
               end
               if (bus_idle) begin
                  gnt_reg   <= 3'b000;
                  state_reg <= ST_IDLE;
               end
            end

`ifdef ARB_BUS_PARK_EN
            // Parked: no timeout. The parked device can start directly or
            // turn the park grant into a normal grant without a gap; anyone
            // else forces a gap through IDLE.
            ST_PARK: begin
               cnt_reg <= '0;
               if (frame_start) begin
                  state_reg <= ST_BUSY;
                  owner_reg <= dev_reg + 2'd1;
                  ptr_reg   <= rot(dev_reg, 1);
               end else if (win_valid) begin
                  if (win_idx == dev_reg) begin
                     state_reg <= ST_GRANT;
                  end else begin
                     gnt_reg   <= 3'b000;
                     state_reg <= ST_IDLE;
                  end
               end
            end
`endif

            default: begin
               gnt_reg   <= 3'b000;
               cnt_reg   <= '0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs (all straight from registers)
   // ---------------------------------------------------------------------
   assign GNT_A     = ~gnt_reg[0];
   assign GNT_B     = ~gnt_reg[1];
   assign GNT_C     = ~gnt_reg[2];
   assign Bus_Owner = owner_reg;
   assign Bus_Busy  = busy_reg;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pci_bus_arbiter
//
// Directed bench for pci_bus_arbiter with the default parameters
// (GNT_TIMEOUT=16, PARK_DEV=0). Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, so every check sees the result of
// the edge just passed. GNT triples are written {GNT_A,GNT_B,GNT_C}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pci_bus_arbiter;

   logic       Clk;
   logic       Rst_n;
   logic       Req_A, Req_B, Req_C;
   logic       Frame, IRDY;
   logic       GNT_A, GNT_B, GNT_C;
   logic [1:0] Bus_Owner;
   logic       Bus_Busy;

   int n_cmp = 0;
   int n_bad = 0;

   pci_bus_arbiter #(
      .GNT_TIMEOUT (16),
      .PARK_DEV    (0)
   ) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Req_A     (Req_A),
      .Req_B     (Req_B),
      .Req_C     (Req_C),
      .Frame     (Frame),
      .IRDY      (IRDY),
      .GNT_A     (GNT_A),
      .GNT_B     (GNT_B),
      .GNT_C     (GNT_C),
      .Bus_Owner (Bus_Owner),
      .Bus_Busy  (Bus_Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      Req_A = 1'b1; Req_B = 1'b1; Req_C = 1'b1;
      Frame = 1'b1; IRDY  = 1'b1;
      tick();
      tick();
      Rst_n = 1'b1;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      Req_A = 1'b1; Req_B = 1'b1; Req_C = 1'b1;
      Frame = 1'b1; IRDY  = 1'b1;
      #2;
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C, Bus_Owner, Bus_Busy} !== {3'b111, 2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_outputs: got gnt=%b%b%b owner=%0d busy=%b want gnt=111 owner=0 busy=0",
                  GNT_A, GNT_B, GNT_C, Bus_Owner, Bus_Busy);
      end
      // Bus activity and requests while reset is held must not register.
      Frame = 1'b0; Req_A = 1'b0;
      tick();
      n_cmp++;
      if ({GNT_A, Bus_Busy} !== 2'b10) begin
         n_bad++;
         $display("FAIL reset_hold: got gnt_a=%b busy=%b want gnt_a=1 busy=0", GNT_A, Bus_Busy);
      end
      Frame = 1'b1; Req_A = 1'b1;
      tick();
      Rst_n = 1'b1;
      #1;
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b111) begin
         n_bad++;
         $display("FAIL reset_release: got gnt=%b%b%b want 111", GNT_A, GNT_B, GNT_C);
      end
      $display("reset: done");
   endtask

   // Single master A: grant latency, ownership and Bus_Busy during a transfer.
   task automatic test_basic();
      Req_A = 1'b0;
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b011) begin
         n_bad++;
         $display("FAIL basic_grant: got gnt=%b%b%b want 011", GNT_A, GNT_B, GNT_C);
      end
      Frame = 1'b0; Req_A = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({GNT_A, GNT_B, GNT_C, Bus_Owner, Bus_Busy} !== {3'b011, 2'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL basic_xfer%0d: got gnt=%b%b%b owner=%0d busy=%b want gnt=011 owner=1 busy=1",
                     i, GNT_A, GNT_B, GNT_C, Bus_Owner, Bus_Busy);
         end
      end
      Frame = 1'b1;
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C, Bus_Owner, Bus_Busy} !== {3'b111, 2'd1, 1'b0}) begin
         n_bad++;
         $display("FAIL basic_end: got gnt=%b%b%b owner=%0d busy=%b want gnt=111 owner=1 busy=0",
                  GNT_A, GNT_B, GNT_C, Bus_Owner, Bus_Busy);
      end
      $display("basic: A transfer of 3 cycles");
   endtask

   // All three request continuously; expected grant order A, B, C, A with a
   // gap cycle between every pair of grants.
   task automatic test_round_robin();
      logic [1:0] exp_order [4];
      logic [2:0] low_prev;
      logic [2:0] low_now;
      logic [1:0] got_idx;
      bit         found;
      exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2; exp_order[3] = 2'd0;
      do_reset();
      Req_A = 1'b0; Req_B = 1'b0; Req_C = 1'b0;
      low_prev = 3'b000;
      for (int k = 0; k < 4; k++) begin
         found   = 1'b0;
         got_idx = 2'd3;
         for (int c = 0; c < 12 && !found; c++) begin
            tick();
            low_now = ~{GNT_C, GNT_B, GNT_A};
            n_cmp++;
            if (!$onehot0(low_now) || (low_prev != 3'b000 && low_now != 3'b000 && low_now != low_prev)) begin
               n_bad++;
               $display("FAIL rr_gap: got low-grant set %b after %b want at most one and a gap between owners",
                        low_now, low_prev);
            end
            low_prev = low_now;
            if (low_now != 3'b000) begin
               found   = 1'b1;
               got_idx = low_now[0] ? 2'd0 : (low_now[1] ? 2'd1 : 2'd2);
            end
         end
         n_cmp++;
         if (got_idx !== exp_order[k]) begin
            n_bad++;
            $display("FAIL rr_order%0d: got device %0d want device %0d", k, got_idx, exp_order[k]);
         end
         $display("round_robin: grant %0d went to device %0d", k, got_idx);
         if (k < 3) begin
            Frame = 1'b0;
            tick();
            tick();
            Frame = 1'b1;
            low_prev = ~{GNT_C, GNT_B, GNT_A};
         end
      end
      Req_A = 1'b1; Req_B = 1'b1; Req_C = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b111) begin
         n_bad++;
         $display("FAIL rr_release: got gnt=%b%b%b want 111", GNT_A, GNT_B, GNT_C);
      end
   endtask

   // B requests while A owns the bus: A loses GNT at once, B waits for idle.
   task automatic test_hidden();
      Req_A = 1'b0;
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b011) begin
         n_bad++;
         $display("FAIL hidden_grant_a: got gnt=%b%b%b want 011", GNT_A, GNT_B, GNT_C);
      end
      Frame = 1'b0; Req_A = 1'b1;
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C, Bus_Owner} !== {3'b011, 2'd1}) begin
         n_bad++;
         $display("FAIL hidden_busy_a: got gnt=%b%b%b owner=%0d want gnt=011 owner=1",
                  GNT_A, GNT_B, GNT_C, Bus_Owner);
      end
      Req_B = 1'b0;
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b111) begin
         n_bad++;
         $display("FAIL hidden_drop_a: got gnt=%b%b%b want 111", GNT_A, GNT_B, GNT_C);
      end
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b111) begin
         n_bad++;
         $display("FAIL hidden_wait_b: got gnt=%b%b%b want 111", GNT_A, GNT_B, GNT_C);
      end
      Frame = 1'b1;
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C, Bus_Busy} !== 4'b1110) begin
         n_bad++;
         $display("FAIL hidden_idle: got gnt=%b%b%b busy=%b want gnt=111 busy=0",
                  GNT_A, GNT_B, GNT_C, Bus_Busy);
      end
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b101) begin
         n_bad++;
         $display("FAIL hidden_grant_b: got gnt=%b%b%b want 101", GNT_A, GNT_B, GNT_C);
      end
      Req_B = 1'b1;
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b111) begin
         n_bad++;
         $display("FAIL hidden_release_b: got gnt=%b%b%b want 111", GNT_A, GNT_B, GNT_C);
      end
      $display("hidden: A transfer, B granted after idle, B withdrew");
   endtask

   // C is granted but never starts: grant lasts exactly 16 cycles, then the
   // pointer has moved past C so A wins a simultaneous A/C request.
   task automatic test_timeout();
      int low_cycles;
      Req_C = 1'b0;
      tick();
      low_cycles = 0;
      if (GNT_C === 1'b0) begin
         low_cycles = 1;
         for (int c = 0; c < 40 && GNT_C === 1'b0; c++) begin
            tick();
            if (GNT_C === 1'b0) low_cycles++;
         end
      end
      n_cmp++;
      if (low_cycles != 16) begin
         n_bad++;
         $display("FAIL timeout_len: got GNT_C low for %0d cycles want 16", low_cycles);
      end
      Req_A = 1'b0;
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b011) begin
         n_bad++;
         $display("FAIL timeout_next: got gnt=%b%b%b want 011", GNT_A, GNT_B, GNT_C);
      end
      Req_A = 1'b1; Req_C = 1'b1;
      tick();
      tick();
      $display("timeout: C held grant %0d cycles, A won next", low_cycles);
   endtask

   // Asynchronous reset in the middle of B's transfer.
   task automatic test_async_reset();
      do_reset();
      Req_B = 1'b0;
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b101) begin
         n_bad++;
         $display("FAIL areset_grant_b: got gnt=%b%b%b want 101", GNT_A, GNT_B, GNT_C);
      end
      Frame = 1'b0;
      tick();
      n_cmp++;
      if ({GNT_B, Bus_Owner, Bus_Busy} !== {1'b0, 2'd2, 1'b1}) begin
         n_bad++;
         $display("FAIL areset_busy_b: got gnt_b=%b owner=%0d busy=%b want gnt_b=0 owner=2 busy=1",
                  GNT_B, Bus_Owner, Bus_Busy);
      end
      #2;
      Rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C, Bus_Owner, Bus_Busy} !== {3'b111, 2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL areset_immediate: got gnt=%b%b%b owner=%0d busy=%b want gnt=111 owner=0 busy=0",
                  GNT_A, GNT_B, GNT_C, Bus_Owner, Bus_Busy);
      end
      Frame = 1'b1; Req_B = 1'b1;
      tick();
      Rst_n = 1'b1;
      tick();
      $display("async_reset: reset applied mid-transfer");
   endtask

`ifdef ARB_BUS_PARK_EN
   task automatic test_park();
      do_reset();
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b011) begin
         n_bad++;
         $display("FAIL park_a: got gnt=%b%b%b want 011", GNT_A, GNT_B, GNT_C);
      end
      Req_C = 1'b0;
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b111) begin
         n_bad++;
         $display("FAIL park_gap: got gnt=%b%b%b want 111", GNT_A, GNT_B, GNT_C);
      end
      tick();
      n_cmp++;
      if ({GNT_A, GNT_B, GNT_C} !== 3'b110) begin
         n_bad++;
         $display("FAIL park_grant_c: got gnt=%b%b%b want 110", GNT_A, GNT_B, GNT_C);
      end
      Req_C = 1'b1;
      tick();
      $display("park: A parked, C granted after gap");
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
`ifdef ARB_BUS_PARK_EN
      test_park();
`else
      test_basic();
      test_round_robin();
      test_hidden();
      test_timeout();
      test_async_reset();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
